// File: rtl/axil_pkg.sv
// rtl/axil_pkg.sv - AXI4-Lite response codes and data-memory bridge FSM states
package axil_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'd0,
    EXOKAY = 2'd1,
    SLVERR = 2'd2,
    DECERR = 2'd3
  } axil_resp_t;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_RESP,
    DONE
  } dmem_state_e;

endpackage

// File: rtl/dmem_axil_bridge.sv
// rtl/dmem_axil_bridge.sv - core data port to AXI4-Lite master bridge
// One transaction at a time; the core is stalled until the single-cycle DONE response.
module dmem_axil_bridge #(
  parameter int XLEN   = 32,
  parameter int STRB_W = XLEN / 8
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              data_valid,
  input  logic              data_wen,
  input  logic [XLEN-1:0]   data_addr,
  input  logic [STRB_W-1:0] data_wstrb,
  input  logic [XLEN-1:0]   data_wdata,
  output logic [XLEN-1:0]   data_rdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic              stall,
  output logic              awvalid,
  input  logic              awready,
  output logic [XLEN-1:0]   awaddr,
  output logic              wvalid,
  input  logic              wready,
  output logic [XLEN-1:0]   wdata,
  output logic [STRB_W-1:0] wstrb,
  input  logic              bvalid,
  output logic              bready,
  input  logic [1:0]        bresp,
  output logic              arvalid,
  input  logic              arready,
  output logic [XLEN-1:0]   araddr,
  input  logic              rvalid,
  output logic              rready,
  input  logic [XLEN-1:0]   rdata,
  input  logic [1:0]        rresp
);
  import axil_pkg::*;

  dmem_state_e       state_q, state_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;

  // Word alignment drops the byte offset; lane selection is done upstream.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^data_addr[1:0];

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (state_q)
      IDLE: begin
        if (data_valid) begin
          addr_d    = {data_addr[XLEN-1:2], 2'b00};
          wdata_d   = data_wdata;
          wstrb_d   = data_wstrb;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = data_wen ? WR_REQ : RD_ADDR;
        end
      end
      RD_ADDR: begin
        if (arready) state_d = RD_DATA;
      end
      RD_DATA: begin
        if (rvalid) begin
          rdata_d = rdata;
          err_d   = (rresp != OKAY);
          state_d = DONE;
        end
      end
      WR_REQ: begin
        // The two write channels complete independently, in any order.
        if (awvalid && awready) aw_done_d = 1'b1;
        if (wvalid && wready)   w_done_d  = 1'b1;
        if (aw_done_d && w_done_d) state_d = WR_RESP;
      end
      WR_RESP: begin
        if (bvalid) begin
          err_d   = (bresp != OKAY);
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign arvalid    = (state_q == RD_ADDR);
  assign araddr     = addr_q;
  assign rready     = (state_q == RD_DATA);
  assign awvalid    = (state_q == WR_REQ) && !aw_done_q;
  assign awaddr     = addr_q;
  assign wvalid     = (state_q == WR_REQ) && !w_done_q;
  assign wdata      = wdata_q;
  assign wstrb      = wstrb_q;
  assign bready     = (state_q == WR_RESP);
  assign rsp_valid  = (state_q == DONE);
  assign rsp_err    = (state_q == DONE) && err_q;
  assign data_rdata = rdata_q;
  assign stall      = data_valid && (state_q != DONE);

endmodule

// File: tb/tb_dmem_axil_bridge.sv
// tb/tb_dmem_axil_bridge.sv - directed self-checking bench for dmem_axil_bridge
module tb_dmem_axil_bridge;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        data_valid = 1'b0, data_wen = 1'b0;
  logic [31:0] data_addr = '0, data_wdata = '0;
  logic [3:0]  data_wstrb = '0;
  logic [31:0] data_rdata;
  logic        rsp_valid, rsp_err, stall;
  logic        awvalid, awready = 1'b0, wvalid, wready = 1'b0;
  logic        bvalid = 1'b0, bready, arvalid, arready = 1'b0, rvalid = 1'b0, rready;
  logic [31:0] awaddr, wdata, araddr, rdata = '0;
  logic [3:0]  wstrb;
  logic [1:0]  bresp = 2'd0, rresp = 2'd0;

  dmem_axil_bridge #(.XLEN(32), .STRB_W(4)) dut (
    .clk(clk), .rst_b(rst_b),
    .data_valid(data_valid), .data_wen(data_wen), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_rdata(data_rdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .stall(stall),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model_rdata = '0;
  int          tests = 0, fails = 0;

  // Slave knobs: wait cycles before each ready/valid, and response payload.
  int          ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0;
  logic [31:0] s_rdata = '0;
  logic [1:0]  s_rresp = 2'd0, s_bresp = 2'd0;

  int          ar_hs = 0, aw_hs = 0, w_hs = 0, b_hs = 0, aw_rise = 0;
  int          ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
  bit          r_pend = 0, aw_got = 0, w_got = 0, aw_prev = 0;
  logic [31:0] last_araddr = '0, last_awaddr = '0, last_wdata = '0;
  logic [3:0]  last_wstrb = '0;

  // Handshakes are observed mid-cycle; slave outputs change just after the edge.
  always begin
    @(negedge clk);
    if (!rst_b) begin
      r_pend = 0; aw_got = 0; w_got = 0; aw_prev = 0;
    end else begin
      if (arvalid && arready) begin ar_hs++; r_pend = 1; last_araddr = araddr; end
      if (rvalid && rready) r_pend = 0;
      if (awvalid && !aw_prev) aw_rise++;
      aw_prev = awvalid;
      if (awvalid && awready) begin aw_hs++; aw_got = 1; last_awaddr = awaddr; end
      if (wvalid && wready) begin w_hs++; w_got = 1; last_wdata = wdata; last_wstrb = wstrb; end
      if (bvalid && bready) begin b_hs++; aw_got = 0; w_got = 0; end
    end
    @(posedge clk);
    #1;
    if (!rst_b) begin
      ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
      arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
    end else begin
      ar_cnt  = arvalid ? ar_cnt + 1 : 0;
      arready = arvalid && (ar_cnt > ar_wait);
      aw_cnt  = awvalid ? aw_cnt + 1 : 0;
      awready = awvalid && (aw_cnt > aw_wait);
      w_cnt   = wvalid ? w_cnt + 1 : 0;
      wready  = wvalid && (w_cnt > w_wait);
      r_cnt   = r_pend ? r_cnt + 1 : 0;
      rvalid  = r_pend && (r_cnt > r_wait);
      rdata   = rvalid ? s_rdata : 32'h0;
      rresp   = s_rresp;
      b_cnt   = (aw_got && w_got) ? b_cnt + 1 : 0;
      bvalid  = aw_got && w_got && (b_cnt > b_wait);
      bresp   = s_bresp;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic req_start(input bit align, input bit wen, input logic [31:0] addr,
                           input logic [3:0] strb, input logic [31:0] wd,
                           input logic [31:0] exp_rd, input bit exp_err);
    exp_t e;
    if (align) begin
      @(posedge clk);
      #1;
    end
    data_valid = 1'b1; data_wen = wen; data_addr = addr; data_wstrb = strb; data_wdata = wd;
    if (!wen) model_rdata = exp_rd;
    e.rdata = model_rdata;
    e.err   = exp_err;
    sb_q.push_back(e);
  endtask

  task automatic req_finish(input string tag, input int exp_stall, input bit drop);
    int   n = 0;
    bit   found = 0;
    exp_t e;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (stall) n++;
      if (rsp_valid) found = 1;
    end
    chk({tag, "_rsp_seen"}, 32'(found), 32'd1);
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_rdata"}, data_rdata, e.rdata);
      chk({tag, "_err"}, 32'(rsp_err), 32'(e.err));
    end
    chk({tag, "_stall_cycles"}, 32'(n), 32'(exp_stall));
    @(posedge clk);
    #1;
    if (drop) begin
      data_valid = 1'b0;
      @(negedge clk);
      chk({tag, "_rsp_pulse"}, 32'(rsp_valid), 32'd0);
      chk({tag, "_idle_stall"}, 32'(stall), 32'd0);
    end
  endtask

  initial begin
    int a0, w0, r0, ar0;

    repeat (2) @(negedge clk);
    chk("rst_arvalid", 32'(arvalid), 32'd0);
    chk("rst_rready", 32'(rready), 32'd0);
    chk("rst_awvalid", 32'(awvalid), 32'd0);
    chk("rst_wvalid", 32'(wvalid), 32'd0);
    chk("rst_bready", 32'(bready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_data_rdata", data_rdata, 32'h0);
    chk("rst_stall", 32'(stall), 32'd0);
    @(posedge clk);
    #2;
    rst_b = 1'b1;

    s_rdata = 32'hDEADBEEF; s_rresp = 2'd0;
    req_start(1, 0, 32'h80000104, 4'h0, 32'h0, 32'hDEADBEEF, 0);
    req_finish("load0", 3, 1);
    chk("load0_araddr", last_araddr, 32'h80000104);

    s_rdata = 32'h12345678;
    req_start(1, 0, 32'h80000106, 4'h0, 32'h0, 32'h12345678, 0);
    req_finish("load_unal", 3, 1);
    chk("load_unal_araddr", last_araddr, 32'h80000104);

    a0 = aw_hs; w0 = w_hs; r0 = aw_rise;
    w_wait = 2;
    req_start(1, 1, 32'h80000010, 4'b0001, 32'h000000AB, 32'h0, 0);
    req_finish("st_wlate", 5, 1);
    w_wait = 0;
    chk("st_wlate_aw_hs", 32'(aw_hs - a0), 32'd1);
    chk("st_wlate_w_hs", 32'(w_hs - w0), 32'd1);
    chk("st_wlate_aw_rise", 32'(aw_rise - r0), 32'd1);
    chk("st_wlate_awaddr", last_awaddr, 32'h80000010);
    chk("st_wlate_wstrb", 32'(last_wstrb), 32'h1);
    chk("st_wlate_wdata", last_wdata, 32'h000000AB);

    a0 = aw_hs; w0 = w_hs;
    req_start(1, 1, 32'h80000022, 4'hF, 32'hCAFEF00D, 32'h0, 0);
    req_finish("st_zero", 3, 1);
    chk("st_zero_hs", 32'((aw_hs - a0) + (w_hs - w0)), 32'd2);
    chk("st_zero_awaddr", last_awaddr, 32'h80000020);
    chk("st_zero_wdata", last_wdata, 32'hCAFEF00D);

    s_rdata = 32'h0BADF00D; s_rresp = 2'd2;
    req_start(1, 0, 32'h80000040, 4'h0, 32'h0, 32'h0BADF00D, 1);
    req_finish("ld_slverr", 3, 0);
    s_rdata = 32'h55AA55AA; s_rresp = 2'd0;
    req_start(0, 0, 32'h80000200, 4'h0, 32'h0, 32'h55AA55AA, 0);
    req_finish("ld_b2b_ok", 3, 1);
    chk("ld_b2b_araddr", last_araddr, 32'h80000200);

    ar_wait = 1; r_wait = 2; s_rdata = 32'hA5A5F00F;
    req_start(1, 0, 32'h80000300, 4'h0, 32'h0, 32'hA5A5F00F, 0);
    req_finish("ld_wait", 6, 1);
    ar_wait = 0; r_wait = 0;

    s_bresp = 2'd3;
    req_start(1, 1, 32'h80000404, 4'hC, 32'h12340000, 32'h0, 1);
    req_finish("st_decerr", 3, 1);
    s_bresp = 2'd0;

    r_wait = 5; s_rdata = 32'h600DCAFE;
    req_start(1, 0, 32'h80000500, 4'h0, 32'h0, 32'h600DCAFE, 0);
    @(posedge clk);
    @(posedge clk);
    #3;
    chk("rst_mid_pre_rready", 32'(rready), 32'd1);
    rst_b = 1'b0;
    #1;
    chk("rst_mid_arvalid", 32'(arvalid), 32'd0);
    chk("rst_mid_rready", 32'(rready), 32'd0);
    chk("rst_mid_stall", 32'(stall), 32'(data_valid));
    chk("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    @(posedge clk);
    #2;
    ar0 = ar_hs;
    r_wait = 0;
    rst_b = 1'b1;
    req_finish("rst_relaunch", 3, 1);
    chk("rst_relaunch_ar_hs", 32'(ar_hs - ar0), 32'd1);
    chk("rst_relaunch_araddr", last_araddr, 32'h80000500);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dmem_axil_bridge.md
# dmem_axil_bridge

Data-memory bridge between the core's single-cycle data port (`data_valid`/`data_wen`/`data_addr`/`data_wstrb`/`data_wdata`/`data_rdata`) and an AXI4-Lite master interface. It sits directly downstream of the core's MEU output. It replaces the zero-latency DPI memory model with a real bus transaction. While a transaction is outstanding it asserts `stall`, which freezes PC update and register/CSR writeback.

## Interface
Parameters:
- `XLEN`, 32, data/address width
- `STRB_W`, `XLEN/8`, write-strobe width

Ports:
- `clk`  in  1  core clock
- `rst_b`  in  1  asynchronous, active-low reset
- `data_valid`  in  1  core memory request present (combinational from the decoder)
- `data_wen`  in  1  1 = store, 0 = load
- `data_addr`  in  XLEN  byte address
- `data_wstrb`  in  STRB_W  byte enables, already lane-aligned by MEU
- `data_wdata`  in  XLEN  store data, already lane-aligned
- `data_rdata`  out  XLEN  load data, full aligned word; valid when `rsp_valid`
- `rsp_valid`  out  1  one-cycle pulse: transaction complete
- `rsp_err`  out  1  bus returned non-OKAY; qualified by `rsp_valid`
- `stall`  out  1  core must not commit this cycle
- `awvalid`/`awready`/`awaddr`, `wvalid`/`wready`/`wdata`/`wstrb`, `bvalid`/`bready`/`bresp[1:0]`  AXI4-Lite write channels
- `arvalid`/`arready`/`araddr`, `rvalid`/`rready`/`rdata`/`rresp[1:0]`  AXI4-Lite read channels

## Operation
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- IDLE with `data_valid`:
  - Capture `addr = {data_addr[XLEN-1:2], 2'b00}`, `wdata`, and `wstrb` into registers.
  - Go to WR_REQ if `data_wen`, else RD_ADDR.
- RD_ADDR: `arvalid` = 1, `araddr` = captured addr. Advance to RD_DATA on `arready`.
- RD_DATA: `rready` = 1. On `rvalid`, latch `rdata` into `data_rdata`, set `err = (rresp != OKAY)`, and go to DONE.
- WR_REQ: `awvalid` and `wvalid` are driven independently.
  - Flags `aw_done`/`w_done` are set on the respective handshake; each valid drops once its flag is set.
  - Both handshakes may occur in the same cycle or in either order.
  - Go to WR_RESP when both are done (counting the current cycle's handshakes).
- WR_RESP: `bready` = 1. On `bvalid`, set `err = (bresp != OKAY)` and go to DONE.
- DONE: `rsp_valid` = 1, `rsp_err` = err. Always return to IDLE.
  - The core still presents the same request in this cycle; it must not be relaunched.
- `stall` = `data_valid && state != DONE`. This is combinational, so a request is stalled from its first cycle.
- `data_rdata` holds its last loaded value until the next read completes. It is not updated by writes.
- `rsp_err` is reported only. Trap generation is the TRAP block's responsibility.

## Timing
- Reset values (asynchronous, `rst_b` low):
  - State = IDLE.
  - All `*valid` and `*ready` outputs = 0.
  - `rsp_valid` = 0, `rsp_err` = 0, `data_rdata` = 0, `aw_done` = `w_done` = 0.
- Zero-wait slave, load: request seen in cycle 0 → `arvalid` cycle 1 → `rready`/`rvalid` cycle 2 → `rsp_valid` cycle 3. That is 3 stall cycles, with commit at the end of cycle 3.
- Zero-wait slave, store: AW and W handshake in cycle 1, B in cycle 2, `rsp_valid` in cycle 3.
- Each slave wait cycle adds exactly one cycle of latency.
- AXI rules: once asserted, a valid stays high with stable payload until its handshake. Valids never depend combinationally on the corresponding ready.
- `data_valid` deasserting mid-transaction (not legal from the core): the transaction still completes, and `rsp_valid` still pulses.
- Reset mid-transaction: immediate return to IDLE and all valids drop. The slave is assumed to be reset together with the bridge.
- Back-to-back requests: DONE → IDLE costs one cycle, during which `stall` = 1 if the next request is already present.

## Structure
- Shared package `axil_pkg`:
  - `axil_resp_t` with values OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3.
  - `dmem_state_e` state enum.
- Single module. No sub-module is needed.
- Write-channel tracking is two flag registers inside WR_REQ.

## Test plan
- Load, zero-wait slave: addr 0x80000104, slave `rdata` 0xDEADBEEF, OKAY → `araddr` = 0x80000104; `stall` high for 3 cycles; `rsp_valid` pulse with `data_rdata` = 0xDEADBEEF and `rsp_err` = 0.
- Unaligned load, addr 0x80000106 → `araddr` = 0x80000104 and the full word is returned.
- Store with `wready` 2 cycles after `awready`: addr 0x80000010, `wdata` 0x000000AB, `wstrb` 0b0001 → single AW handshake and single W handshake; `wstrb` = 0x1; `rsp_valid` 1 cycle after `bvalid`; `awvalid` never reasserted.
- Store with AW and W both ready in the same cycle → B phase on the next cycle; 3-cycle total latency.
- Read returning SLVERR (`rresp` = 2) → `rsp_valid` with `rsp_err` = 1. The following OKAY read returns `rsp_err` = 0.
- `rst_b` pulsed low while in RD_DATA → `arvalid`/`rready` = 0 and `stall` = `data_valid` immediately. After release, a new request starts a fresh AR phase.
